dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer in front of the `dmem` data memory. It shares `dmem` between the CPU load/store unit (port 0) and a secondary master such as DMA or debug (port 1). Each port uses a valid/ready request channel and a valid/ready response channel. The block converts byte-addressed byte/half/word accesses into word-aligned `dmem` strobes with lane-shifted write data, and returns sign- or zero-extended load data. One transaction is in flight at a time, and ports are granted round-robin.

## Interface
Parameters:
- `ADDR_W`, 14: byte-address width; the `dmem` word index is `addr[ADDR_W-1:2]`.

Ports (clock and reset first; `mN_` applies to N = 0 and 1):
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mN_req_valid`  in  1  request present.
- `mN_req_ready`  out  1  request accepted this cycle.
- `mN_req_we`  in  1  1 = store, 0 = load.
- `mN_req_size`  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- `mN_req_unsigned`  in  1  zero-extend load data (otherwise sign-extend).
- `mN_req_addr`  in  ADDR_W  byte address.
- `mN_req_wdata`  in  32  store data, LSB-justified.
- `mN_resp_valid`  out  1  response present.
- `mN_resp_ready`  in  1  response consumed.
- `mN_resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `mN_resp_err`  out  1  misaligned or illegal-size access.
- `dmem_en`  out  1  memory enable.
- `dmem_we`  out  4  byte write strobes.
- `dmem_addr`  out  ADDR_W  word-aligned byte address; bits [1:0] always 00.
- `dmem_din`  out  32  lane-replicated store data.
- `dmem_dout`  in  32  combinational read data for `dmem_addr`.

## Operation
- FSM states:
  - IDLE: `req_ready` is high toward the port chosen by the arbiter.
  - ACCESS: `dmem_en`=1 and the strobes are driven for exactly one cycle.
  - RESP: `resp_valid` is held toward the granted port.
- Transitions:
  - IDLE → ACCESS when a request handshake occurs.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE on `resp_ready`.
  - If the access is in error, IDLE → RESP directly and ACCESS is skipped.
- Arbitration:
  - In IDLE only one `mN_req_ready` is high.
  - If only one port has `req_valid`, that port gets `req_ready`.
  - If both are valid, the port other than the last granted one wins.
  - The last-grant pointer resets to 1, so port 0 wins the first contention.
- Request latching: the request fields are registered on acceptance. Port inputs are don't-care until the next handshake.
- Alignment and errors:
  - A half access with `addr[0]`=1 is an error.
  - A word access with `addr[1:0]`≠00 is an error.
  - `size`=11 is an error.
  - An error access never asserts `dmem_en`.
- Store strobes:
  - byte: `dmem_we` = 0001<<`addr[1:0]`, `dmem_din` = {4{wdata[7:0]}}.
  - half: `dmem_we` = 0011<<`addr[1:0]`, `dmem_din` = {2{wdata[15:0]}}.
  - word: `dmem_we` = 1111, `dmem_din` = wdata.
- Loads: `dmem_we`=0000. `dmem_dout` is captured at the end of ACCESS, then the addressed lane is selected and extended to 32 bits per `unsigned`.
- Outside ACCESS: `dmem_en`, `dmem_we`, `dmem_addr` and `dmem_din` are all 0.

## Timing
- Latency: handshake at edge N → ACCESS in cycle N+1 (store commits at edge N+2) → `resp_valid` from cycle N+2.
- Error accesses: `resp_valid` from cycle N+1.
- Throughput: at most one access per 3 cycles. `req_ready` is low in ACCESS and RESP.
- Response hold: `resp_valid`, `rdata` and `err` are held stable until `resp_ready`. `resp_ready` may be high before `resp_valid`; the response then completes in its first cycle.
- Reset (`rst_n`=0, at any time including mid-ACCESS):
  - state returns to IDLE and the pointer to 1.
  - all `req_ready`, `resp_valid`, `resp_err` and `dmem_*` outputs are 0 immediately; `resp_rdata` is 0.
  - a store cut off by reset may or may not have committed. The bench must not check its memory contents.
- The response port is fixed to the granted port; the other port's `resp_valid` stays 0.

## Structure
- Package `dmem_arb_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - state encodings `ST_IDLE`, `ST_ACCESS`, `ST_RESP`.
  - error function for the alignment check.
- Sub-module `dmem_lane_align`: purely combinational; computes `we`, `din`, and extracted/extended `rdata` from size, `addr[1:0]`, `unsigned`, `wdata` and `dout`. It is instantiated once.

## Test plan
- Port 0 stores byte 0xA5 to 0x0007 → `dmem_we`=1000, `dmem_din`=0xA5A5A5A5, `dmem_addr`=0x0004. A following signed byte load from 0x0007 → `rdata`=0xFFFFFFA5; an unsigned load → 0x000000A5.
- Half store 0x8001 at 0x0012, then a signed half load → `dmem_we`=1100, `rdata`=0xFFFF8001. A word load of 0x0010 shows 0x8001 in bits [31:16].
- Both ports valid for 4 consecutive requests → grants alternate 0,1,0,1 starting at port 0. Each response appears 2 cycles after its handshake.
- Word load at 0x0002 and `size`=11 → `resp_err`=1 at N+1, `rdata`=0, and `dmem_en` never asserts.
- `resp_ready` held low for 5 cycles → the response is stable, `req_ready` stays low, and the other port is starved until release.
- `rst_n` pulsed low during ACCESS → all outputs are 0 during reset. After release the first request completes normally with pointer = 1.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared encodings and helpers for the dmem arbiter slice.
//   SZ_*       : request size encodings (byte/half/word; 2'b11 is illegal)
//   state_t    : sequencer states ST_IDLE / ST_ACCESS / ST_RESP
//   access_err : alignment / illegal-size check on size and addr[1:0]
package dmem_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: access_err = 1'b0;
      SZ_HALF: access_err = addr_lo[0];
      SZ_WORD: access_err = (addr_lo != 2'b00);
      default: access_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering between a byte-addressed
// access and the 32-bit word-wide dmem.
//   size, addr_lo, is_unsigned : latched access attributes
//   wdata                      : LSB-justified store data
//   dout                       : raw dmem read word
//   we, din                    : byte strobes and lane-replicated store data
//   rdata                      : selected lane, sign- or zero-extended
module dmem_lane_align
  import dmem_arb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] dout,
  output logic [3:0]  we,
  output logic [31:0] din,
  output logic [31:0] rdata
);

  logic [31:0]        shifted;
  logic signed [7:0]  b8;
  logic signed [15:0] h16;

  always_comb begin
    we      = 4'b0000;
    din     = 32'd0;
    rdata   = 32'd0;
    // Move the addressed lane down to bit 0; half accesses are 2-byte aligned
    // here, so the same shift serves both byte and half extraction.
    shifted = dout >> {addr_lo, 3'b000};
    b8      = shifted[7:0];
    h16     = shifted[15:0];
    case (size)
      SZ_BYTE: begin
        we    = 4'b0001 << addr_lo;
        din   = {4{wdata[7:0]}};
        rdata = is_unsigned ? {24'd0, b8} : {{24{b8[7]}}, b8};
      end
      SZ_HALF: begin
        we    = 4'b0011 << addr_lo;
        din   = {2{wdata[15:0]}};
        rdata = is_unsigned ? {16'd0, h16} : {{16{h16[15]}}, h16};
      end
      SZ_WORD: begin
        we    = 4'b1111;
        din   = wdata;
        rdata = dout;
      end
      default: begin
        we    = 4'b0000;
        din   = 32'd0;
        rdata = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and access sequencer for dmem.
//   clk, rst_n            : clock, asynchronous active-low reset
//   mN_req_*  (N = 0, 1)  : valid/ready request channel (we, size, unsigned,
//                           byte address, LSB-justified store data)
//   mN_resp_* (N = 0, 1)  : valid/ready response channel (rdata, err)
//   dmem_*                : word-aligned memory port, active only in ACCESS
// One transaction is in flight at a time: IDLE -> ACCESS -> RESP -> IDLE,
// with erroneous accesses going IDLE -> RESP without touching memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_we,
  input  logic [1:0]        m0_req_size,
  input  logic              m0_req_unsigned,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [31:0]       m0_req_wdata,
  output logic              m0_resp_valid,
  input  logic              m0_resp_ready,
  output logic [31:0]       m0_resp_rdata,
  output logic              m0_resp_err,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_we,
  input  logic [1:0]        m1_req_size,
  input  logic              m1_req_unsigned,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [31:0]       m1_req_wdata,
  output logic              m1_resp_valid,
  input  logic              m1_resp_ready,
  output logic [31:0]       m1_resp_rdata,
  output logic              m1_resp_err,
  output logic              dmem_en,
  output logic [3:0]        dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_din,
  input  logic [31:0]       dmem_dout
);

  state_t            state;
  logic              last_grant;
  logic              grant;
  logic              sel;
  logic              idle;
  logic              access;
  logic              hs;
  logic              resp_done;

  logic              req_we;
  logic              req_uns;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              req_err;

  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [3:0]        lane_we;
  logic [31:0]       lane_din;
  logic [31:0]       lane_rdata;

  // A lone requester wins outright; on contention (or with no requester) the
  // candidate is the port that was not granted last.
  always_comb begin
    case ({m1_req_valid, m0_req_valid})
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      default: sel = ~last_grant;
    endcase
  end

  assign req_we    = sel ? m1_req_we       : m0_req_we;
  assign req_uns   = sel ? m1_req_unsigned : m0_req_unsigned;
  assign req_size  = sel ? m1_req_size     : m0_req_size;
  assign req_addr  = sel ? m1_req_addr     : m0_req_addr;
  assign req_wdata = sel ? m1_req_wdata    : m0_req_wdata;
  assign req_err   = access_err(req_size, req_addr[1:0]);

  assign idle      = (state == ST_IDLE);
  assign access    = (state == ST_ACCESS);
  assign hs        = idle && (sel ? m1_req_valid : m0_req_valid);
  assign resp_done = (state == ST_RESP) && (grant ? m1_resp_ready : m0_resp_ready);

  // rst_n gating keeps ready low throughout reset, not just after the first edge.
  assign m0_req_ready = rst_n && idle && !sel;
  assign m1_req_ready = rst_n && idle &&  sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hs) begin
            grant      <= sel;
            last_grant <= sel;
            state      <= req_err ? ST_RESP : ST_ACCESS;
          end
        end
        ST_ACCESS: state <= ST_RESP;
        ST_RESP:   if (resp_done) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Request capture and response data; outputs are qualified by state, so
  // these registers need no reset.
  always_ff @(posedge clk) begin
    if (hs) begin
      we_q    <= req_we;
      uns_q   <= req_uns;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      err_q   <= req_err;
      rdata_q <= 32'd0;
    end else if (access) begin
      rdata_q <= we_q ? 32'd0 : lane_rdata;
    end
  end

  dmem_lane_align u_lane_align (
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .dout        (dmem_dout),
    .we          (lane_we),
    .din         (lane_din),
    .rdata       (lane_rdata)
  );

  assign dmem_en   = access;
  assign dmem_we   = (access && we_q) ? lane_we : 4'b0000;
  assign dmem_addr = access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_din  = (access && we_q) ? lane_din : 32'd0;

  assign m0_resp_valid = (state == ST_RESP) && !grant;
  assign m1_resp_valid = (state == ST_RESP) &&  grant;
  assign m0_resp_rdata = m0_resp_valid ? rdata_q : 32'd0;
  assign m1_resp_rdata = m1_resp_valid ? rdata_q : 32'd0;
  assign m0_resp_err   = m0_resp_valid && err_q;
  assign m1_resp_err   = m1_resp_valid && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a word memory
// behind the dmem port and a byte-level shadow model for expectations.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [1:0]  req_size  [2];
  logic        req_uns   [2];
  logic [13:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid[2];
  logic        resp_ready[2];
  logic [31:0] resp_rdata[2];
  logic        resp_err  [2];
  logic        dmem_en;
  logic [3:0]  dmem_we;
  logic [13:0] dmem_addr;
  logic [31:0] dmem_din;
  logic [31:0] dmem_dout;

  logic [31:0] mem [0:4095];
  logic [7:0]  sh  [0:16383];

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          hs;
  } exp_t;

  exp_t sbq[$];
  int   gq[$];
  exp_t mon_e;
  bit   seen[2];
  int   cyc;
  int   n_chk;
  int   n_err;

  dmem_arbiter #(.ADDR_W(14)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .m0_req_valid    (req_valid[0]),
    .m0_req_ready    (req_ready[0]),
    .m0_req_we       (req_we[0]),
    .m0_req_size     (req_size[0]),
    .m0_req_unsigned (req_uns[0]),
    .m0_req_addr     (req_addr[0]),
    .m0_req_wdata    (req_wdata[0]),
    .m0_resp_valid   (resp_valid[0]),
    .m0_resp_ready   (resp_ready[0]),
    .m0_resp_rdata   (resp_rdata[0]),
    .m0_resp_err     (resp_err[0]),
    .m1_req_valid    (req_valid[1]),
    .m1_req_ready    (req_ready[1]),
    .m1_req_we       (req_we[1]),
    .m1_req_size     (req_size[1]),
    .m1_req_unsigned (req_uns[1]),
    .m1_req_addr     (req_addr[1]),
    .m1_req_wdata    (req_wdata[1]),
    .m1_resp_valid   (resp_valid[1]),
    .m1_resp_ready   (resp_ready[1]),
    .m1_resp_rdata   (resp_rdata[1]),
    .m1_resp_err     (resp_err[1]),
    .dmem_en         (dmem_en),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_din        (dmem_din),
    .dmem_dout       (dmem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Memory behind the arbiter: combinational read, strobed write.
  assign dmem_dout = mem[dmem_addr[13:2]];
  always @(posedge clk) begin
    if (dmem_en) begin
      for (int k = 0; k < 4; k++)
        if (dmem_we[k]) mem[dmem_addr[13:2]][8*k +: 8] <= dmem_din[8*k +: 8];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic uns, input logic [13:0] a);
    logic [7:0]  v8;
    logic [15:0] v16;
    int          i;
    i = int'(a);
    case (sz)
      2'b00: begin
        v8 = sh[i];
        exp_load = uns ? {24'd0, v8} : {{24{v8[7]}}, v8};
      end
      2'b01: begin
        v16 = {sh[i+1], sh[i]};
        exp_load = uns ? {16'd0, v16} : {{16{v16[15]}}, v16};
      end
      default: exp_load = {sh[i+3], sh[i+2], sh[i+1], sh[i]};
    endcase
  endfunction

  // Drive one request on port p, wait for its handshake, record expectations,
  // then check the dmem port during the following (ACCESS) cycle.
  task automatic issue(input int p, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [13:0] a, input logic [31:0] wd);
    int          t;
    bit          got;
    int          i;
    exp_t        e;
    logic        is_err;
    logic [3:0]  we_e;
    logic [31:0] din_e;
    req_we[p]    = we;
    req_size[p]  = sz;
    req_uns[p]   = uns;
    req_addr[p]  = a;
    req_wdata[p] = wd;
    req_valid[p] = 1'b1;
    t   = 0;
    got = 0;
    while (!got && t < 60) begin
      @(negedge clk);
      if (req_ready[p]) got = 1;
      else t++;
    end
    if (!got) begin
      check_val("hs_timeout", 32'd0, 32'd1);
      req_valid[p] = 1'b0;
      return;
    end
    i      = int'(a);
    is_err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    e.port  = p;
    e.hs    = cyc;
    e.err   = is_err;
    e.lat   = is_err ? 1 : 2;
    e.rdata = 32'd0;
    we_e    = 4'b0000;
    din_e   = 32'd0;
    if (!is_err) begin
      if (we) begin
        case (sz)
          2'b00: begin
            sh[i] = wd[7:0];
            we_e  = 4'b0001 << a[1:0];
            din_e = {4{wd[7:0]}};
          end
          2'b01: begin
            sh[i]   = wd[7:0];
            sh[i+1] = wd[15:8];
            we_e    = 4'b0011 << a[1:0];
            din_e   = {2{wd[15:0]}};
          end
          default: begin
            sh[i]   = wd[7:0];
            sh[i+1] = wd[15:8];
            sh[i+2] = wd[23:16];
            sh[i+3] = wd[31:24];
            we_e    = 4'b1111;
            din_e   = wd;
          end
        endcase
      end else begin
        e.rdata = exp_load(sz, uns, a);
      end
    end
    sbq.push_back(e);
    gq.push_back(p);
    @(posedge clk);
    #1;
    // Request inputs become don't-care once accepted; scramble them.
    req_valid[p] = 1'b0;
    req_addr[p]  = 14'($urandom);
    req_wdata[p] = $urandom;
    req_size[p]  = 2'($urandom);
    req_we[p]    = 1'($urandom);
    @(negedge clk);
    if (is_err) begin
      check_val("err_dmem_en", 32'(dmem_en), 32'd0);
    end else begin
      check_val("acc_en", 32'(dmem_en), 32'd1);
      check_val("acc_addr", 32'(dmem_addr), 32'({a[13:2], 2'b00}));
      check_val("acc_we", 32'(dmem_we), 32'(we_e));
      check_val("acc_din", dmem_din, din_e);
    end
  endtask

  // Response monitor: first appearance checks port and latency, the
  // completing cycle pops the scoreboard and checks data and error.
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (resp_valid[p]) begin
        if (sbq.size() == 0) begin
          check_val("resp_unexpected", 32'(resp_valid[p]), 32'd0);
        end else begin
          if (!seen[p]) begin
            seen[p] = 1'b1;
            check_val("resp_port", 32'(p), 32'(sbq[0].port));
            check_val("resp_lat", 32'(cyc - sbq[0].hs), 32'(sbq[0].lat));
          end
          if (resp_ready[p]) begin
            mon_e = sbq.pop_front();
            check_val("resp_rdata", resp_rdata[p], mon_e.rdata);
            check_val("resp_err", 32'(resp_err[p]), 32'(mon_e.err));
            seen[p] = 1'b0;
          end
        end
      end else begin
        seen[p] = 1'b0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_val({tag, "_rdy0"}, 32'(req_ready[0]), 32'd0);
    check_val({tag, "_rdy1"}, 32'(req_ready[1]), 32'd0);
    check_val({tag, "_rv0"}, 32'(resp_valid[0]), 32'd0);
    check_val({tag, "_rv1"}, 32'(resp_valid[1]), 32'd0);
    check_val({tag, "_err"}, 32'({resp_err[1], resp_err[0]}), 32'd0);
    check_val({tag, "_rd0"}, resp_rdata[0], 32'd0);
    check_val({tag, "_rd1"}, resp_rdata[1], 32'd0);
    check_val({tag, "_en"}, 32'(dmem_en), 32'd0);
    check_val({tag, "_we"}, 32'(dmem_we), 32'd0);
    check_val({tag, "_addr"}, 32'(dmem_addr), 32'd0);
    check_val({tag, "_din"}, dmem_din, 32'd0);
  endtask

  initial begin
    int          t;
    bit          got;
    logic [31:0] held;
    cyc   = 0;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    for (int i = 0; i < 16384; i++) sh[i] = 8'd0;
    for (int p = 0; p < 2; p++) begin
      req_valid[p]  = 1'b0;
      req_we[p]     = 1'b0;
      req_size[p]   = 2'b00;
      req_uns[p]    = 1'b0;
      req_addr[p]   = 14'd0;
      req_wdata[p]  = 32'd0;
      resp_ready[p] = 1'b1;
      seen[p]       = 1'b0;
    end
    #2;
    check_all_zero("rst");
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Byte store then signed/unsigned byte loads.
    issue(0, 1'b1, 2'b00, 1'b0, 14'h0007, 32'h000000A5);
    issue(0, 1'b0, 2'b00, 1'b0, 14'h0007, 32'd0);
    issue(0, 1'b0, 2'b00, 1'b1, 14'h0007, 32'd0);
    // Half store / load, then word load of the containing word.
    issue(0, 1'b1, 2'b01, 1'b0, 14'h0012, 32'h00008001);
    issue(0, 1'b0, 2'b01, 1'b0, 14'h0012, 32'd0);
    issue(0, 1'b0, 2'b10, 1'b0, 14'h0010, 32'd0);
    // Port 1 word traffic and unsigned half.
    issue(1, 1'b1, 2'b10, 1'b0, 14'h0020, 32'hCAFEF00D);
    issue(1, 1'b0, 2'b10, 1'b0, 14'h0020, 32'd0);
    issue(1, 1'b0, 2'b01, 1'b1, 14'h0022, 32'd0);
    // Error accesses.
    issue(0, 1'b0, 2'b10, 1'b0, 14'h0002, 32'd0);
    issue(0, 1'b0, 2'b11, 1'b0, 14'h0008, 32'd0);
    issue(1, 1'b1, 2'b01, 1'b0, 14'h0005, 32'h1234);

    // Response back-pressure on port 0 while port 1 waits.
    resp_ready[0] = 1'b0;
    issue(0, 1'b0, 2'b10, 1'b0, 14'h0020, 32'd0);
    fork
      issue(1, 1'b0, 2'b00, 1'b0, 14'h0021, 32'd0);
    join_none
    @(negedge clk);
    held = resp_rdata[0];
    check_val("bp_first_rdata", held, 32'hCAFEF00D);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("bp_valid", 32'(resp_valid[0]), 32'd1);
      check_val("bp_stable", resp_rdata[0], held);
      check_val("bp_rdy0", 32'(req_ready[0]), 32'd0);
      check_val("bp_rdy1", 32'(req_ready[1]), 32'd0);
      check_val("bp_rv1", 32'(resp_valid[1]), 32'd0);
    end
    @(posedge clk);
    #1;
    resp_ready[0] = 1'b1;
    wait fork;

    // Reset asserted in the middle of an ACCESS cycle.
    @(posedge clk);
    #1;
    req_we[0]    = 1'b1;
    req_size[0]  = 2'b10;
    req_addr[0]  = 14'h0100;
    req_wdata[0] = 32'hDEADBEEF;
    req_valid[0] = 1'b1;
    t   = 0;
    got = 0;
    while (!got && t < 60) begin
      @(negedge clk);
      if (req_ready[0]) got = 1;
      else t++;
    end
    if (!got) check_val("rst_hs_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    check_val("pre_rst_en", 32'(dmem_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    req_valid[0] = 1'b1;
    req_valid[1] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_all_zero("inrst");
    end
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention straight after reset: port 0 must win first, then alternate.
    gq.delete();
    fork
      begin
        issue(0, 1'b0, 2'b10, 1'b0, 14'h0010, 32'd0);
        issue(0, 1'b1, 2'b10, 1'b0, 14'h0030, 32'h11223344);
      end
      begin
        issue(1, 1'b1, 2'b10, 1'b0, 14'h0034, 32'h55667788);
        issue(1, 1'b0, 2'b10, 1'b0, 14'h0030, 32'd0);
      end
    join
    check_val("grant_count", 32'(gq.size()), 32'd4);
    if (gq.size() == 4) begin
      check_val("grant0", 32'(gq[0]), 32'd0);
      check_val("grant1", 32'(gq[1]), 32'd1);
      check_val("grant2", 32'(gq[2]), 32'd0);
      check_val("grant3", 32'(gq[3]), 32'd1);
    end

    // Mixed random traffic in a scratch region.
    for (int k = 0; k < 12; k++) begin
      issue(int'($urandom_range(0, 1)), 1'($urandom), 2'($urandom), 1'($urandom),
            14'h0040 + 14'($urandom_range(0, 59)), $urandom);
    end

    t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_val("drain", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
